pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1: branch-flush penalty in cycles, legal range 1..7.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  level; pipeline runs while high.
REQ-006 id_ex_memread_i  in  1  instruction in ID/EX is a load.
REQ-007 id_ex_rd_i  in  5  destination register of the ID/EX instruction.
REQ-008 if_id_rs_i, if_id_rt_i  in  5 each  source registers of the IF/ID instruction.
REQ-009 branch_taken_i  in  1  branch resolved taken this cycle.
REQ-010 dmem_req_i, dmem_ack_i  in  1 each  data-memory request from the MEM stage, and its completion.
REQ-011 pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o  out  1 each  register enables.
REQ-012 id_ex_bubble_o, if_id_flush_o, mem_wb_bubble_o  out  1 each  insert a NOP into the named register.
REQ-013 state_o  out  2  current FSM state.
REQ-014 stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating performance counters.

Function
REQ-015 FSM states: IDLE=0, RUN=1, MEM_WAIT=2, FLUSH=3.
REQ-016 IDLE: all write enables 0, all bubble/flush outputs 0; move to RUN on the edge where start_i=1.
REQ-017 start_i=0 in any state: next state IDLE; any pending flush is discarded.
REQ-018 Load-use hazard (LU) = id_ex_memread_i & (id_ex_rd_i!=0) & (id_ex_rd_i==if_id_rs_i | id_ex_rd_i==if_id_rt_i).
REQ-019 Memory stall (MS) = dmem_req_i & ~dmem_ack_i.
REQ-020 Control outputs are Mealy: they depend on the current state and the current inputs, so the action takes effect in the same cycle.
REQ-021 RUN, priority MS > branch_taken_i > LU > none.
REQ-022 RUN with MS: all four write enables 0 and mem_wb_bubble_o=1; next state MEM_WAIT.
REQ-023 RUN with branch_taken_i: if_id_flush_o=1 and id_ex_bubble_o=1, other enables 1; flush_cnt increments; if FLUSH_CYCLES>1, next state FLUSH with down-counter loaded to FLUSH_CYCLES-1.
REQ-024 RUN with LU only: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; exactly one cycle per LU assertion.
REQ-025 RUN with none of these: all enables 1, all bubbles 0.
REQ-026 MEM_WAIT: outputs as in REQ-022 while MS holds.
REQ-027 MEM_WAIT, dmem_ack_i=1: enables 1 that cycle; next state RUN, or FLUSH if a branch is pending.
REQ-028 A branch_taken_i seen during MEM_WAIT sets branch_pend and is counted once; branch_pend is applied on exit.
REQ-029 FLUSH: if_id_flush_o=1, id_ex_bubble_o=1, pc_write_o=1; counter decrements; at 0 go to RUN.
REQ-030 FLUSH: MS preempts to MEM_WAIT with the remaining count kept.
REQ-031 FLUSH: LU is ignored.
REQ-032 stall_cnt increments on every cycle in which pc_write_o=0 while state!=IDLE.
REQ-033 Both counters saturate at all-ones and never wrap.

Reset
REQ-034 rst_n_i=0 immediately forces: state IDLE, branch_pend 0, flush counter 0, stall_cnt 0, flush_cnt 0, all write enables 0, all bubble/flush outputs 0.
REQ-035 Reset mid-MEM_WAIT or mid-FLUSH discards all pending work.
REQ-036 The first RUN cycle needs start_i=1 sampled after rst_n_i deasserts.

Structure
REQ-037 A shared package holds the state encoding, the register-address width (5), and the NOP-control constants.
REQ-038 One sub-module, hazard_unit, computes LU combinationally and is instantiated once.

Verification
REQ-039 Load-use: RUN, id_ex_memread=1, rd=5, rs=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle; stall_cnt=1.
REQ-040 Register 0: rd=0=rs with a load -> no stall; stall_cnt stays 0.
REQ-041 Memory stall: dmem_req=1, ack after 3 cycles -> all enables 0 for 3 cycles, mem_wb_bubble=1, state_o=2; resume RUN; stall_cnt=3.
REQ-042 Simultaneous events: branch_taken and LU together -> flush only, no LU stall; with FLUSH_CYCLES=3 -> if_id_flush high for 3 cycles; flush_cnt=1.
REQ-043 Branch during MEM_WAIT -> flush deferred until after ack; then FLUSH for FLUSH_CYCLES cycles.
REQ-044 Reset mid-FLUSH and counter saturation: rst_n_i=0 in FLUSH -> all outputs 0 and state IDLE at once; with CNT_W=4 and 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding,
// register-address width and the canned per-cycle control words.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_AW = 5;  // register-file address width
  localparam int unsigned FCNT_W = 3;  // holds flush penalties 1..7

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  // Field order: pc, if_id, id_ex, ex_mem, id_ex_bubble, if_id_flush, mem_wb_bubble
  localparam ctrl_t CTRL_HALT      = 7'b0000_000;
  localparam ctrl_t CTRL_RUN       = 7'b1111_000;
  localparam ctrl_t CTRL_MEM_STALL = 7'b0000_001;
  localparam ctrl_t CTRL_FLUSH     = 7'b1111_110;
  localparam ctrl_t CTRL_LOAD_USE  = 7'b0011_100;

  function automatic logic mem_stall(input logic req, input logic ack);
    return req & ~ack;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-facing signal bundle of the controller. The controller uses the
// slave view; whatever drives the pipeline status uses the master view.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipeline_ctrl_pkg::*;

  logic              start_i;
  logic              id_ex_memread_i;
  logic [REG_AW-1:0] id_ex_rd_i;
  logic [REG_AW-1:0] if_id_rs_i;
  logic [REG_AW-1:0] if_id_rt_i;
  logic              branch_taken_i;
  logic              dmem_req_i;
  logic              dmem_ack_i;

  logic              pc_write_o;
  logic              if_id_write_o;
  logic              id_ex_write_o;
  logic              ex_mem_write_o;
  logic              id_ex_bubble_o;
  logic              if_id_flush_o;
  logic              mem_wb_bubble_o;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output start_i, id_ex_memread_i, id_ex_rd_i, if_id_rs_i, if_id_rt_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o,
           id_ex_bubble_o, if_id_flush_o, mem_wb_bubble_o, state_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, id_ex_memread_i, id_ex_rd_i, if_id_rs_i, if_id_rt_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o,
           id_ex_bubble_o, if_id_flush_o, mem_wb_bubble_o, state_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detection: a load in ID/EX whose destination (other than
// r0) feeds either source of the instruction in IF/ID.
module hazard_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic              id_ex_memread_i,
  input  logic [REG_AW-1:0] id_ex_rd_i,
  input  logic [REG_AW-1:0] if_id_rs_i,
  input  logic [REG_AW-1:0] if_id_rt_i,
  output logic              load_use_o
);

  // Purely combinational compare.
  always_comb begin
    load_use_o = id_ex_memread_i & (id_ex_rd_i != '0) &
                 ((id_ex_rd_i == if_id_rs_i) | (id_ex_rd_i == if_id_rt_i));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: a four-state FSM with Mealy control
// outputs, a flush-penalty down-counter, a deferred-branch flag and two
// saturating performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,  // legal range 1..7
  parameter int unsigned CNT_W        = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [FCNT_W-1:0] FC_FULL = FCNT_W'(FLUSH_CYCLES);
  localparam logic [FCNT_W-1:0] FC_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               pend_q, pend_d;
  logic               lu_seen_q, lu_seen_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  ctrl_t ctrl;
  logic  lu, ms, br, flush_inc, lu_take, stall_inc;

  hazard_unit u_hazard (
    .id_ex_memread_i (bus.id_ex_memread_i),
    .id_ex_rd_i      (bus.id_ex_rd_i),
    .if_id_rs_i      (bus.if_id_rs_i),
    .if_id_rt_i      (bus.if_id_rt_i),
    .load_use_o      (lu)
  );

  assign ms = mem_stall(bus.dmem_req_i, bus.dmem_ack_i);
  assign br = bus.branch_taken_i;

  // Next-state, flush-counter, pending-branch and Mealy control word.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    pend_d    = pend_q;
    ctrl      = CTRL_HALT;
    flush_inc = 1'b0;
    lu_take   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ms) begin
          ctrl    = CTRL_MEM_STALL;
          state_d = ST_MEM_WAIT;
        end else if (br) begin
          ctrl      = CTRL_FLUSH;
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_LOAD;
          end
        end else if (lu && !lu_seen_q) begin
          ctrl    = CTRL_LOAD_USE;
          lu_take = 1'b1;
        end else begin
          ctrl = CTRL_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // A branch seen here is counted once and replayed as a full flush on exit.
        if (br && !pend_q) flush_inc = 1'b1;
        if (br) pend_d = 1'b1;
        if (ms) begin
          ctrl = CTRL_MEM_STALL;
        end else begin
          ctrl   = CTRL_RUN;
          pend_d = 1'b0;
          if (pend_q || br) begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_FULL;
          end else if (fcnt_q != '0) begin
            state_d = ST_FLUSH;  // resume a flush that a memory stall preempted
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (ms) begin
          ctrl    = CTRL_MEM_STALL;
          state_d = ST_MEM_WAIT;
        end else begin
          ctrl   = CTRL_FLUSH;
          fcnt_d = fcnt_q - FCNT_W'(1);
          if (fcnt_q == FCNT_W'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!bus.start_i) begin
      state_d = ST_IDLE;
      fcnt_d  = '0;
      pend_d  = 1'b0;
    end
  end

  // One stall per load-use assertion; re-arms once the hazard clears.
  always_comb begin
    lu_seen_d = lu & (lu_seen_q | lu_take);
  end

  // Saturating performance counter updates.
  always_comb begin
    stall_inc   = (state_q != ST_IDLE) & ~ctrl.pc_write;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      fcnt_q      <= '0;
      pend_q      <= 1'b0;
      lu_seen_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_q      <= pend_d;
      lu_seen_q   <= lu_seen_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_write_o      = ctrl.pc_write;
  assign bus.if_id_write_o   = ctrl.if_id_write;
  assign bus.id_ex_write_o   = ctrl.id_ex_write;
  assign bus.ex_mem_write_o  = ctrl.ex_mem_write;
  assign bus.id_ex_bubble_o  = ctrl.id_ex_bubble;
  assign bus.if_id_flush_o   = ctrl.if_id_flush;
  assign bus.mem_wb_bubble_o = ctrl.mem_wb_bubble;
  assign bus.state_o         = state_q;
  assign bus.stall_cnt_o     = stall_cnt_q;
  assign bus.flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random
// traffic, each cycle predicted by a behavioural model and checked by an
// independent monitor on the falling edge.
module tb_pipeline_ctrl;

  localparam int FC     = 3;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    bit [6:0] ctrl;   // pc, if_id, id_ex, ex_mem, id_ex_bubble, if_id_flush, mem_wb_bubble
    int       state;
    int       stall;
    int       flush;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Behavioural model state
  bit m_running, m_waiting, m_pend, m_lu_used;
  int m_flush_left, m_stall, m_flush;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_waiting = 0; m_pend = 0; m_lu_used = 0;
    m_flush_left = 0; m_stall = 0; m_flush = 0;
  endtask

  // Predict this cycle's outputs, queue them, then advance one clock.
  task automatic model_step(input bit st, input bit mr, input int rd, input int rs,
                            input int rt, input bit br, input bit rq, input bit ak);
    exp_t e;
    bit ms, lu, took_lu;
    bit pc, ifid, idex, exm, bub, fl, wb;
    ms = rq && !ak;
    lu = mr && (rd != 0) && (rd == rs || rd == rt);
    {pc, ifid, idex, exm, bub, fl, wb} = 7'b0;
    took_lu = 0;
    if (m_running) begin
      if (ms) wb = 1;
      else if (m_waiting) {pc, ifid, idex, exm} = 4'hF;
      else if (m_flush_left > 0 || br) {pc, ifid, idex, exm, bub, fl} = 6'h3F;
      else if (lu && !m_lu_used) begin
        {idex, exm, bub} = 3'b111;
        took_lu = 1;
      end else {pc, ifid, idex, exm} = 4'hF;
    end
    e.ctrl  = {pc, ifid, idex, exm, bub, fl, wb};
    e.state = !m_running ? 0 : m_waiting ? 2 : (m_flush_left > 0) ? 3 : 1;
    e.stall = m_stall;
    e.flush = m_flush;
    sb_q.push_back(e);

    if (m_running && !pc && m_stall < CNTMAX) m_stall++;
    if (m_running && br && m_flush < CNTMAX) begin
      if (m_waiting ? !m_pend : (!ms && m_flush_left == 0)) m_flush++;
    end
    m_lu_used = lu && (m_lu_used || took_lu);

    if (!st) begin
      m_running = 0; m_waiting = 0; m_flush_left = 0; m_pend = 0;
    end else if (!m_running) begin
      m_running = 1;
    end else if (m_waiting) begin
      if (br) m_pend = 1;
      if (!ms) begin
        m_waiting = 0;
        if (m_pend) begin
          m_flush_left = FC;
          m_pend = 0;
        end
      end
    end else if (m_flush_left > 0) begin
      if (ms) m_waiting = 1;
      else m_flush_left--;
    end else begin
      if (ms) m_waiting = 1;
      else if (br) m_flush_left = FC - 1;
    end
  endtask

  // Apply one cycle of inputs just after the rising edge; returns with
  // outputs settled and well before the falling edge.
  task automatic drive(input bit st, input bit mr, input int rd, input int rs,
                       input int rt, input bit br, input bit rq, input bit ak);
    @(posedge clk);
    #1;
    bus.start_i         = st;
    bus.id_ex_memread_i = mr;
    bus.id_ex_rd_i      = 5'(rd);
    bus.if_id_rs_i      = 5'(rs);
    bus.if_id_rt_i      = 5'(rt);
    bus.branch_taken_i  = br;
    bus.dmem_req_i      = rq;
    bus.dmem_ack_i      = ak;
    model_step(st, mr, rd, rs, rt, br, rq, ak);
    #2;
  endtask

  task automatic run_clean();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n               = 1'b0;
    bus.start_i         = 1'b0;
    bus.id_ex_memread_i = 1'b0;
    bus.id_ex_rd_i      = '0;
    bus.if_id_rs_i      = '0;
    bus.if_id_rt_i      = '0;
    bus.branch_taken_i  = 1'b0;
    bus.dmem_req_i      = 1'b0;
    bus.dmem_ack_i      = 1'b0;
    #1;
    chk("rst_state", int'(bus.state_o), 0);
    chk("rst_ctrl", int'({bus.pc_write_o, bus.if_id_write_o, bus.id_ex_write_o,
                          bus.ex_mem_write_o, bus.id_ex_bubble_o, bus.if_id_flush_o,
                          bus.mem_wb_bubble_o}), 0);
    chk("rst_stall_cnt", int'(bus.stall_cnt_o), 0);
    chk("rst_flush_cnt", int'(bus.flush_cnt_o), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ctrl", int'({bus.pc_write_o, bus.if_id_write_o, bus.id_ex_write_o,
                          bus.ex_mem_write_o, bus.id_ex_bubble_o, bus.if_id_flush_o,
                          bus.mem_wb_bubble_o}), int'(e.ctrl));
        chk("state", int'(bus.state_o), e.state);
        chk("stall_cnt", int'(bus.stall_cnt_o), e.stall);
        chk("flush_cnt", int'(bus.flush_cnt_o), e.flush);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Load-use stall of exactly one cycle
    run_clean();
    drive(1, 1, 5, 5, 7, 0, 0, 0);
    chk("lu_pc_write", int'(bus.pc_write_o), 0);
    chk("lu_if_id_write", int'(bus.if_id_write_o), 0);
    chk("lu_bubble", int'(bus.id_ex_bubble_o), 1);
    run_clean();
    chk("lu_release", int'(bus.pc_write_o), 1);
    chk("lu_stall_cnt", int'(bus.stall_cnt_o), 1);

    // Held load-use only stalls once
    drive(1, 1, 6, 2, 6, 0, 0, 0);
    drive(1, 1, 6, 2, 6, 0, 0, 0);
    chk("lu_held_once", int'(bus.pc_write_o), 1);

    // r0 never creates a hazard
    do_reset();
    run_clean();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk("r0_pc_write", int'(bus.pc_write_o), 1);
    run_clean();
    chk("r0_stall_cnt", int'(bus.stall_cnt_o), 0);

    // Memory stall, ack on the fourth cycle
    do_reset();
    run_clean();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      chk("ms_pc_write", int'(bus.pc_write_o), 0);
      chk("ms_wb_bubble", int'(bus.mem_wb_bubble_o), 1);
    end
    chk("ms_state", int'(bus.state_o), 2);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    chk("ms_ack_pc_write", int'(bus.pc_write_o), 1);
    run_clean();
    chk("ms_resume_state", int'(bus.state_o), 1);
    chk("ms_stall_cnt", int'(bus.stall_cnt_o), 3);

    // Branch together with load-use: flush wins, lasts FC cycles
    do_reset();
    run_clean();
    drive(1, 1, 4, 4, 0, 1, 0, 0);
    chk("br_lu_pc_write", int'(bus.pc_write_o), 1);
    chk("br_lu_flush", int'(bus.if_id_flush_o), 1);
    for (int i = 0; i < FC - 1; i++) begin
      drive(1, 1, 4, 4, 0, 0, 0, 0);
      chk("flush_hold", int'(bus.if_id_flush_o), 1);
      chk("flush_state", int'(bus.state_o), 3);
    end
    run_clean();
    chk("flush_end", int'(bus.if_id_flush_o), 0);
    chk("flush_cnt_one", int'(bus.flush_cnt_o), 1);

    // Branch during memory wait is deferred past the ack
    do_reset();
    run_clean();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    chk("defer_ack_flush", int'(bus.if_id_flush_o), 0);
    for (int i = 0; i < FC; i++) begin
      run_clean();
      chk("defer_flush", int'(bus.if_id_flush_o), 1);
    end
    run_clean();
    chk("defer_done_state", int'(bus.state_o), 1);
    chk("defer_flush_cnt", int'(bus.flush_cnt_o), 1);

    // Reset in the middle of a flush
    do_reset();
    run_clean();
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    run_clean();
    chk("pre_rst_state", int'(bus.state_o), 3);
    do_reset();

    // Stall counter saturation
    run_clean();
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    chk("stall_sat", int'(bus.stall_cnt_o), CNTMAX);

    // Random traffic in several reset-separated segments
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        drive($urandom_range(0, 99) < 95,
              1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              $urandom_range(0, 99) < 12,
              $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 40);
      end
    end

    @(negedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
